div_ratio_ctrl: RTL and testbench

- Configuration front-end that sits directly upstream of the integer clock divider and drives its `div_ratio` and `clk_en` inputs.
- Accepts ratio-change requests over a valid/ready handshake and gates the divider off for a fixed quiesce window. It then loads the new ratio and re-enables the divider, so the ratio never changes while the divider is counting.
- Also flags ratios of 0/1, which put the divider in pass-through.

---
 rtl/div_ratio_ctrl_pkg.sv | 16 +
 rtl/div_ratio_ctrl.sv | 124 ++++++++++++
 tb/tb_div_ratio_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_ratio_ctrl_pkg.sv
// Shared types and constants for the divider ratio controller and the divider.
package div_ratio_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_QUIESCE = 2'd2,
    ST_APPLY   = 2'd3
  } state_e;

  localparam int RATIO_W_DEF = 8;

  // Ratios at or below this value make the divider pass the reference clock.
  localparam int BYPASS_MAX = 1;

endpackage

// File: rtl/div_ratio_ctrl.sv
// Ratio-change front-end for the integer clock divider: gates the divider off,
// waits a quiesce window, loads the new ratio, then re-enables it.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | divider disabled (stopped or pass-through), accepting requests
// RUN     | divider enabled with the applied ratio, accepting requests
// QUIESCE | enable held low while the quiesce window counts down
// APPLY   | one cycle: pending ratio moves to the divider output
module div_ratio_ctrl
  import div_ratio_ctrl_pkg::*;
#(
  parameter int                 RATIO_W     = RATIO_W_DEF,
  parameter int                 QUIESCE_CYC = 4,
  parameter logic [RATIO_W-1:0] RST_RATIO   = RATIO_W'(2)
) (
  input  logic               i_ref_clk,
  input  logic               i_rst,
  input  logic               i_cfg_valid,
  input  logic [RATIO_W-1:0] i_cfg_ratio,
  output logic               o_cfg_ready,
  input  logic               i_run_req,
  output logic [RATIO_W-1:0] o_div_ratio,
  output logic               o_clk_en,
  output logic               o_bypass,
  output logic               o_busy
);

  localparam int                 CNT_W    = $clog2(QUIESCE_CYC + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [RATIO_W-1:0] BYP_LIM  = RATIO_W'(BYPASS_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RATIO_W-1:0] pend_q, pend_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic               byp_q, byp_d;
  logic               en_q, en_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic               cur_open, nxt_open;

  assign accept = i_cfg_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ratio_d = ratio_q;
    byp_d   = byp_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          pend_d  = i_cfg_ratio;
          state_d = ST_QUIESCE;
        // ready_q low only in the settle cycle after reset or APPLY
        end else if (i_run_req && !byp_q && ready_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          pend_d  = i_cfg_ratio;
          state_d = ST_QUIESCE;
        end else if (!i_run_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_APPLY: begin
        ratio_d = pend_q;
        byp_d   = (pend_q <= BYP_LIM);
        state_d = (i_run_req && (pend_q > BYP_LIM)) ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cur_open = (state_q == ST_IDLE) || (state_q == ST_RUN);
    nxt_open = (state_d == ST_IDLE) || (state_d == ST_RUN);

    // Coming out of APPLY the enable waits a cycle so the new ratio settles first.
    en_d    = (state_d == ST_RUN) && cur_open;
    ready_d = cur_open && nxt_open;
    busy_d  = !ready_d;
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= RST_RATIO;
      ratio_q <= RST_RATIO;
      byp_q   <= (RST_RATIO <= BYP_LIM);
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ratio_q <= ratio_d;
      byp_q   <= byp_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_div_ratio = ratio_q;
  assign o_clk_en    = en_q;
  assign o_bypass    = byp_q;
  assign o_cfg_ready = ready_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Scoreboard bench for div_ratio_ctrl: requests push expected results, a monitor
// pops them when the busy window closes.
module tb_div_ratio_ctrl;

  localparam int QC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] ratio;
  logic       ready;
  logic       run_req;
  logic [7:0] div_ratio;
  logic       clk_en;
  logic       bypass;
  logic       busy;

  typedef struct {
    logic [7:0] r;
    bit         en;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_sent = 0;
  bit   saw6 = 0;

  div_ratio_ctrl #(.RATIO_W(8), .QUIESCE_CYC(QC), .RST_RATIO(8'd2)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_cfg_valid(valid),
    .i_cfg_ratio(ratio),
    .o_cfg_ready(ready),
    .i_run_req  (run_req),
    .o_div_ratio(div_ratio),
    .o_clk_en   (clk_en),
    .o_bypass   (bypass),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Accepts happen at the posedge; sampled before the DUT's registers update.
  initial forever begin
    @(posedge clk);
    if (!rst && valid && ready) n_acc++;
  end

  initial begin : monitor
    bit         busy_p;
    logic [7:0] ratio_p;
    exp_t       e;
    busy_p  = 0;
    ratio_p = 8'd2;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_p  = 0;
        ratio_p = div_ratio;
      end else begin
        if (div_ratio == 8'd6) saw6 = 1;
        if (clk_en) chk("ratio_stable_while_en", div_ratio, ratio_p);
        if (busy_p && !busy) begin
          if (sb.size() == 0) begin
            chk("unexpected_busy_end", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("applied_ratio", div_ratio, e.r);
            chk("applied_bypass", bypass, (e.r < 8'd2));
            chk("clk_en_after_seq", clk_en, e.en);
            chk("seq_latency", cyc - e.acc, QC + 2);
          end
        end
        busy_p  = busy;
        ratio_p = div_ratio;
      end
    end
  end

  task automatic send(input logic [7:0] r, input bit en_exp, input bit hold, input bit track);
    int   t;
    exp_t e;
    @(negedge clk);
    valid = 1'b1;
    ratio = r;
    t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      chk("ready_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    if (track) begin
      e.r   = r;
      e.en  = en_exp;
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    n_sent++;
    @(negedge clk);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("seq_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; ratio = 8'd0; run_req = 1'b1;

    // 1: reset values, then release
    repeat (2) @(negedge clk);
    chk("rst_ratio", div_ratio, 2);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_ready", ready, 0);
    chk("rst_bypass", bypass, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("e1_clk_en", clk_en, 0);
    chk("e1_ready", ready, 1);
    chk("e1_ratio", div_ratio, 2);
    chk("e1_bypass", bypass, 0);
    @(negedge clk);
    chk("e2_clk_en", clk_en, 1);

    // 2: ratio 5 from RUN, timing of the window
    send(8'd5, 1, 0, 1);
    chk("n1_clk_en", clk_en, 0);
    chk("n1_ready", ready, 0);
    chk("n1_busy", busy, 1);
    repeat (4) @(negedge clk);
    chk("n4_ratio_old", div_ratio, 2);
    chk("n4_busy", busy, 1);
    @(negedge clk);
    chk("n5_ratio_new", div_ratio, 5);
    chk("n5_clk_en", clk_en, 0);
    chk("n5_ready", ready, 0);
    chk("n5_busy", busy, 1);
    wait_idle();

    // 3: bypass ratio then back to a dividing ratio
    send(8'd1, 0, 0, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("byp_hold_clk_en", clk_en, 0);
    chk("byp_hold_bypass", bypass, 1);
    chk("byp_ready", ready, 1);
    send(8'd4, 1, 0, 1);
    wait_idle();

    // 4: valid held through busy, then a second request
    send(8'd7, 1, 1, 1);
    repeat (3) @(negedge clk);
    send(8'd9, 1, 0, 1);
    wait_idle();
    chk("final_ratio_9", div_ratio, 9);

    // 5: reset during QUIESCE discards the pending ratio
    send(8'd6, 0, 0, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_ratio", div_ratio, 2);
    chk("mid_rst_clk_en", clk_en, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bypass", bypass, 0);
    @(negedge clk); #2 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_ratio", div_ratio, 2);
    chk("ratio6_never_seen", saw6, 0);
    chk("post_rst_clk_en", clk_en, 1);

    // 6: run_req drops during APPLY, then rises again
    send(8'd3, 0, 0, 1);
    repeat (4) @(negedge clk);
    run_req = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("idle_clk_en", clk_en, 0);
    run_req = 1'b1;
    @(negedge clk);
    chk("rerun_clk_en", clk_en, 1);

    repeat (2) @(negedge clk);
    chk("accept_count", n_acc, n_sent);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
